exe_stage_pipe: RTL and testbench
=================================

// Module: exe_stage_pipe
// PURPOSE
//  Parametrised ARM execute stage with built-in EXE/MEM pipeline register. Single-cycle ALU ops
//  and branch-target calculation. Iterative MUL/MLA unit that stalls upstream via in_ready.
//  Sits between the ID/EXE register and the memory stage. Honours freeze (downstream stall) and
//  flush (branch taken).
// PARAMETERS
//  DATA_W    32  register/ALU width
//  ADDR_W    32  PC / branch address width
//  CMD_W     4   execute command width
//  MUL_RADIX 4   multiplier bits retired per cycle; DATA_W % MUL_RADIX == 0
// PORTS
//  clk              in   1        clock, rising edge
//  rst              in   1        synchronous active-high reset
//  in_valid         in   1        ID/EXE holds a valid instruction
//  in_ready         out  1        stage accepts the instruction this cycle
//  freeze           in   1        downstream stall; hold all outputs
//  flush            in   1        kill the in-flight instruction
//  pc_in            in   ADDR_W   PC+4 of the instruction
//  wb_en_in, mem_read_in, mem_write_in, s_in, branch_taken_in  in  1 each  control bits
//  mul_in, acc_in   in   1        multiply op; accumulate (MLA)
//  exe_cmd_in       in   CMD_W    ALU command
//  val_rn, val_rm   in   DATA_W   operands; val_rm is also the store data
//  val2_in          in   DATA_W   shifted/immediate operand 2; the multiplier (Rs) for MUL
//  imm24            in   24       signed branch offset, in words
//  dest_in          in   4        destination register
//  status_in        in   4        current {N,Z,C,V}
//  out_valid        out  1        EXE/MEM register holds a valid instruction
//  pc_out           out  ADDR_W   registered pc_in
//  wb_en_out, mem_read_out, mem_write_out  out  1  registered control bits
//  dest_out         out  4        registered dest_in
//  alu_res          out  DATA_W   ALU or multiply result
//  st_val           out  DATA_W   registered val_rm
//  status_out       out  4        new {N,Z,C,V}
//  status_we        out  1        s_in & out_valid, one cycle per instruction
//  branch_out       out  1        branch_taken_in & out_valid
//  branch_addr      out  ADDR_W   pc_in + (sext(imm24) << 2), wraps modulo 2^ADDR_W
// BEHAVIOUR
//  Reset: all outputs 0. State IDLE. in_ready = 1 after reset.
//  in_ready = (state==IDLE) & ~freeze.
//  Accept = in_valid & in_ready.
//  IDLE, accept of a non-mul op: EXE/MEM register loads on that edge, so latency is 1 cycle.
//  ALU commands:
//   0001 MOV  = v2
//   1001 MVN  = ~v2
//   0010 ADD  = rn+v2
//   0011 ADC  = rn+v2+C
//   0100 SUB  = rn-v2
//   0101 SBC  = rn-v2-~C
//   0110 AND
//   0111 ORR
//   1000 EOR
//   others: result 0, flags unchanged.
//  Flags:
//   N = res[DATA_W-1]; Z = (res==0).
//   C = carry-out for add; C = NOT borrow for sub.
//   V = signed overflow for add/sub.
//   C and V pass through status_in for logic ops and MOV/MVN.
//  LDR/STR use ADD (0010); the address is in alu_res.
//  IDLE, accept of mul_in=1: latch rm, val2_in, rn, acc_in and all control bits; clear the
//   accumulator; go to MUL. Output register: out_valid <= 0.
//  MUL: one MUL_RADIX-bit slice of val2 is retired per cycle, LSB first.
//   Runs for DATA_W/MUL_RADIX cycles; count 0..L-1.
//   On the last cycle, load the output register with res = low DATA_W of rm*v2 + (acc ? rn : 0).
//   Flags for the result: N/Z updated; C/V = status_in.
//   Then return to IDLE. in_ready is low for the whole MUL state.
//  Not accepting in IDLE, no freeze: out_valid <= 0 (bubble). Data outputs may hold.
//  freeze=1: every output register and the MUL counter hold; state does not advance.
//  flush=1 (priority over freeze):
//   out_valid, status_we and branch_out are 0 next cycle.
//   MUL aborts to IDLE; any instruction presented that cycle is dropped.
//   Other data outputs are don't-care.
//  rst mid-MUL: returns to IDLE; counter cleared; outputs zero.
//  Simultaneous flush and rst: rst wins.
// TESTING
//  1. ADD rn=5, v2=7, s_in=1
//     -> next cycle: alu_res=12, status_out=0000, status_we=1, out_valid=1.
//  2. SUB rn=3, v2=5
//     -> alu_res=0xFFFFFFFE, N=1, Z=0, C=0, V=0.
//     ADD 0x7FFFFFFF+1 -> V=1, N=1.
//  3. MUL rm=0x1234, v2=0x10
//     -> in_ready low for 8 cycles, then out_valid=1 with alu_res=0x12340.
//     MLA with rn=1 -> 0x12341.
//  4. Branch pc_in=0x100, imm24=0xFFFFFE, branch_taken_in=1
//     -> branch_addr=0xF8, branch_out=1.
//     imm24=0x000001 -> 0x104.
//  5. freeze high 3 cycles mid-MUL
//     -> result is delayed exactly 3 cycles and is still correct; outputs are stable while frozen.
//  6. flush on cycle 4 of a MUL
//     -> out_valid stays 0, state returns to IDLE, in_ready=1 on the next cycle, no status_we.
//     Then reset during MUL -> all outputs 0.

Source files
------------

// File: rtl/exe_stage_pipe.sv
// ARM execute stage with EXE/MEM output register.
// Single-cycle ALU/branch path plus an iterative radix-N MUL/MLA unit.
module exe_stage_pipe #(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int CMD_W     = 4,
    parameter int MUL_RADIX = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              freeze,
    input  logic              flush,
    input  logic [ADDR_W-1:0] pc_in,
    input  logic              wb_en_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              s_in,
    input  logic              branch_taken_in,
    input  logic              mul_in,
    input  logic              acc_in,
    input  logic [CMD_W-1:0]  exe_cmd_in,
    input  logic [DATA_W-1:0] val_rn,
    input  logic [DATA_W-1:0] val_rm,
    input  logic [DATA_W-1:0] val2_in,
    input  logic [23:0]       imm24,
    input  logic [3:0]        dest_in,
    input  logic [3:0]        status_in,
    output logic              out_valid,
    output logic [ADDR_W-1:0] pc_out,
    output logic              wb_en_out,
    output logic              mem_read_out,
    output logic              mem_write_out,
    output logic [3:0]        dest_out,
    output logic [DATA_W-1:0] alu_res,
    output logic [DATA_W-1:0] st_val,
    output logic [3:0]        status_out,
    output logic              status_we,
    output logic              branch_out,
    output logic [ADDR_W-1:0] branch_addr
);

    localparam int L   = DATA_W / MUL_RADIX;
    localparam int CW  = (L > 1) ? $clog2(L) : 1;
    localparam int MSB = DATA_W - 1;

    localparam logic [CMD_W-1:0] CMD_MOV = CMD_W'(1);
    localparam logic [CMD_W-1:0] CMD_ADD = CMD_W'(2);
    localparam logic [CMD_W-1:0] CMD_ADC = CMD_W'(3);
    localparam logic [CMD_W-1:0] CMD_SUB = CMD_W'(4);
    localparam logic [CMD_W-1:0] CMD_SBC = CMD_W'(5);
    localparam logic [CMD_W-1:0] CMD_AND = CMD_W'(6);
    localparam logic [CMD_W-1:0] CMD_ORR = CMD_W'(7);
    localparam logic [CMD_W-1:0] CMD_EOR = CMD_W'(8);
    localparam logic [CMD_W-1:0] CMD_MVN = CMD_W'(9);

    typedef enum logic {S_IDLE, S_MUL} state_t;

    state_t r_state;
    state_t w_state_nx;

    logic [CW-1:0]     r_cnt;
    logic [DATA_W-1:0] r_mcand;
    logic [DATA_W-1:0] r_mplier;
    logic [DATA_W-1:0] r_macc;
    logic [DATA_W-1:0] r_m_rn;
    logic [DATA_W-1:0] r_m_rm;
    logic              r_m_acc;
    logic              r_m_wb;
    logic              r_m_mr;
    logic              r_m_mw;
    logic              r_m_s;
    logic              r_m_br;
    logic [3:0]        r_m_dest;
    logic [ADDR_W-1:0] r_m_pc;
    logic [ADDR_W-1:0] r_m_baddr;

    logic              r_valid;
    logic [ADDR_W-1:0] r_pc;
    logic              r_wb;
    logic              r_mr;
    logic              r_mw;
    logic [3:0]        r_dest;
    logic [DATA_W-1:0] r_res;
    logic [DATA_W-1:0] r_st;
    logic [3:0]        r_status;
    logic              r_swe;
    logic              r_br;
    logic [ADDR_W-1:0] r_baddr;

    logic              w_accept;
    logic              w_last;
    logic [ADDR_W-1:0] w_off;
    logic [ADDR_W-1:0] w_baddr;
    logic [DATA_W-1:0] w_b;
    logic              w_cin;
    logic              w_arith;
    logic              w_nz_upd;
    logic [DATA_W:0]   w_sum;
    logic [DATA_W-1:0] w_res;
    logic              w_c;
    logic              w_v;
    logic [3:0]        w_flags;
    logic [DATA_W-1:0] w_pp;
    logic [DATA_W-1:0] w_macc_nx;
    logic [DATA_W-1:0] w_mres;
    logic [3:0]        w_mflags;

    assign in_ready = (r_state == S_IDLE) && !freeze;
    assign w_accept = in_valid && in_ready;
    assign w_last   = (r_cnt == CW'(L - 1));

    assign w_off   = {{(ADDR_W-24){imm24[23]}}, imm24};
    assign w_baddr = pc_in + {w_off[ADDR_W-3:0], 2'b00};

    always_comb begin
        w_b      = val2_in;
        w_cin    = 1'b0;
        w_arith  = 1'b0;
        w_nz_upd = 1'b1;
        w_res    = '0;
        w_c      = status_in[1];
        w_v      = status_in[0];
        case (exe_cmd_in)
            CMD_MOV: w_res = val2_in;
            CMD_MVN: w_res = ~val2_in;
            CMD_ADD: w_arith = 1'b1;
            CMD_ADC: begin
                w_arith = 1'b1;
                w_cin   = status_in[1];
            end
            CMD_SUB: begin
                w_arith = 1'b1;
                w_b     = ~val2_in;
                w_cin   = 1'b1;
            end
            CMD_SBC: begin
                w_arith = 1'b1;
                w_b     = ~val2_in;
                w_cin   = status_in[1];
            end
            CMD_AND: w_res = val_rn & val2_in;
            CMD_ORR: w_res = val_rn | val2_in;
            CMD_EOR: w_res = val_rn ^ val2_in;
            default: w_nz_upd = 1'b0;
        endcase
        // subtract is rn + ~v2 + cin, so the carry out is already NOT borrow
        w_sum = {1'b0, val_rn} + {1'b0, w_b} + {{DATA_W{1'b0}}, w_cin};
        if (w_arith) begin
            w_res = w_sum[DATA_W-1:0];
            w_c   = w_sum[DATA_W];
            w_v   = (val_rn[MSB] == w_b[MSB]) && (w_res[MSB] != val_rn[MSB]);
        end
        w_flags = w_nz_upd ? {w_res[MSB], (w_res == '0), w_c, w_v} : status_in;
    end

    always_comb begin
        w_pp = '0;
        for (int i = 0; i < MUL_RADIX; i++) begin
            if (r_mplier[i]) begin
                w_pp = w_pp + (r_mcand << i);
            end
        end
    end

    assign w_macc_nx = r_macc + w_pp;
    assign w_mres    = w_macc_nx + (r_m_acc ? r_m_rn : '0);
    assign w_mflags  = {w_mres[MSB], (w_mres == '0), status_in[1:0]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        if (flush) begin
            w_state_nx = S_IDLE;
        end else if (!freeze) begin
            case (r_state)
                S_IDLE: if (w_accept && mul_in) w_state_nx = S_MUL;
                S_MUL:  if (w_last) w_state_nx = S_IDLE;
                default: w_state_nx = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt     <= '0;
            r_mcand   <= '0;
            r_mplier  <= '0;
            r_macc    <= '0;
            r_m_rn    <= '0;
            r_m_rm    <= '0;
            r_m_acc   <= 1'b0;
            r_m_wb    <= 1'b0;
            r_m_mr    <= 1'b0;
            r_m_mw    <= 1'b0;
            r_m_s     <= 1'b0;
            r_m_br    <= 1'b0;
            r_m_dest  <= '0;
            r_m_pc    <= '0;
            r_m_baddr <= '0;
            r_valid   <= 1'b0;
            r_pc      <= '0;
            r_wb      <= 1'b0;
            r_mr      <= 1'b0;
            r_mw      <= 1'b0;
            r_dest    <= '0;
            r_res     <= '0;
            r_st      <= '0;
            r_status  <= '0;
            r_swe     <= 1'b0;
            r_br      <= 1'b0;
            r_baddr   <= '0;
        end else if (flush) begin
            r_cnt   <= '0;
            r_valid <= 1'b0;
            r_swe   <= 1'b0;
            r_br    <= 1'b0;
        end else if (!freeze) begin
            r_valid <= 1'b0;
            r_swe   <= 1'b0;
            r_br    <= 1'b0;
            if (r_state == S_IDLE) begin
                if (w_accept && !mul_in) begin
                    r_valid  <= 1'b1;
                    r_pc     <= pc_in;
                    r_wb     <= wb_en_in;
                    r_mr     <= mem_read_in;
                    r_mw     <= mem_write_in;
                    r_dest   <= dest_in;
                    r_res    <= w_res;
                    r_st     <= val_rm;
                    r_status <= w_flags;
                    r_swe    <= s_in;
                    r_br     <= branch_taken_in;
                    r_baddr  <= w_baddr;
                end else if (w_accept) begin
                    r_cnt     <= '0;
                    r_macc    <= '0;
                    r_mcand   <= val_rm;
                    r_mplier  <= val2_in;
                    r_m_rn    <= val_rn;
                    r_m_rm    <= val_rm;
                    r_m_acc   <= acc_in;
                    r_m_wb    <= wb_en_in;
                    r_m_mr    <= mem_read_in;
                    r_m_mw    <= mem_write_in;
                    r_m_s     <= s_in;
                    r_m_br    <= branch_taken_in;
                    r_m_dest  <= dest_in;
                    r_m_pc    <= pc_in;
                    r_m_baddr <= w_baddr;
                end
            end else begin
                r_macc   <= w_macc_nx;
                r_mcand  <= r_mcand << MUL_RADIX;
                r_mplier <= r_mplier >> MUL_RADIX;
                r_cnt    <= r_cnt + CW'(1);
                if (w_last) begin
                    r_cnt    <= '0;
                    r_valid  <= 1'b1;
                    r_pc     <= r_m_pc;
                    r_wb     <= r_m_wb;
                    r_mr     <= r_m_mr;
                    r_mw     <= r_m_mw;
                    r_dest   <= r_m_dest;
                    r_res    <= w_mres;
                    r_st     <= r_m_rm;
                    r_status <= w_mflags;
                    r_swe    <= r_m_s;
                    r_br     <= r_m_br;
                    r_baddr  <= r_m_baddr;
                end
            end
        end
    end

    assign out_valid     = r_valid;
    assign pc_out        = r_pc;
    assign wb_en_out     = r_wb;
    assign mem_read_out  = r_mr;
    assign mem_write_out = r_mw;
    assign dest_out      = r_dest;
    assign alu_res       = r_res;
    assign st_val        = r_st;
    assign status_out    = r_status;
    assign status_we     = r_swe;
    assign branch_out    = r_br;
    assign branch_addr   = r_baddr;

endmodule

// File: tb/tb_exe_stage_pipe.sv
// Directed bench for exe_stage_pipe: ALU vector table plus
// hand-written MUL, branch, freeze, flush and reset sequences.
module tb_exe_stage_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        freeze;
    logic        flush;
    logic [31:0] pc_in;
    logic        wb_en_in;
    logic        mem_read_in;
    logic        mem_write_in;
    logic        s_in;
    logic        branch_taken_in;
    logic        mul_in;
    logic        acc_in;
    logic [3:0]  exe_cmd_in;
    logic [31:0] val_rn;
    logic [31:0] val_rm;
    logic [31:0] val2_in;
    logic [23:0] imm24;
    logic [3:0]  dest_in;
    logic [3:0]  status_in;
    logic        out_valid;
    logic [31:0] pc_out;
    logic        wb_en_out;
    logic        mem_read_out;
    logic        mem_write_out;
    logic [3:0]  dest_out;
    logic [31:0] alu_res;
    logic [31:0] st_val;
    logic [3:0]  status_out;
    logic        status_we;
    logic        branch_out;
    logic [31:0] branch_addr;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    exe_stage_pipe dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .freeze(freeze), .flush(flush), .pc_in(pc_in),
        .wb_en_in(wb_en_in), .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in), .s_in(s_in),
        .branch_taken_in(branch_taken_in), .mul_in(mul_in),
        .acc_in(acc_in), .exe_cmd_in(exe_cmd_in), .val_rn(val_rn),
        .val_rm(val_rm), .val2_in(val2_in), .imm24(imm24),
        .dest_in(dest_in), .status_in(status_in),
        .out_valid(out_valid), .pc_out(pc_out), .wb_en_out(wb_en_out),
        .mem_read_out(mem_read_out), .mem_write_out(mem_write_out),
        .dest_out(dest_out), .alu_res(alu_res), .st_val(st_val),
        .status_out(status_out), .status_we(status_we),
        .branch_out(branch_out), .branch_addr(branch_addr)
    );

    typedef struct {
        logic [3:0]  cmd;
        logic [31:0] rn;
        logic [31:0] v2;
        logic [3:0]  st_in;
        logic [31:0] res;
        logic [3:0]  st;
    } vec_t;

    vec_t vecs[14];

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        in_valid = 1'b0; freeze = 1'b0; flush = 1'b0;
        pc_in = '0; wb_en_in = 1'b0; mem_read_in = 1'b0;
        mem_write_in = 1'b0; s_in = 1'b0; branch_taken_in = 1'b0;
        mul_in = 1'b0; acc_in = 1'b0; exe_cmd_in = '0;
        val_rn = '0; val_rm = '0; val2_in = '0; imm24 = '0;
        dest_in = '0; status_in = '0;
    endtask

    // returns just after the accepting edge
    task automatic start_mul(input logic [31:0] rm, input logic [31:0] v2,
                             input logic [31:0] rn, input logic acc);
        @(negedge clk);
        in_valid = 1'b1; mul_in = 1'b1; acc_in = acc; s_in = 1'b1;
        wb_en_in = 1'b1; dest_in = 4'h7; val_rm = rm; val2_in = v2;
        val_rn = rn; status_in = 4'b0011; exe_cmd_in = 4'h0;
        @(posedge clk); #1;
        in_valid = 1'b0; mul_in = 1'b0;
    endtask

    task automatic wait_valid(input int max, output int n);
        n = 0;
        while (!out_valid && n < max) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_mul(input string nm, input logic [31:0] rm,
                           input logic [31:0] v2, input logic [31:0] rn,
                           input logic acc, input logic [31:0] exp);
        int n;
        int low;
        start_mul(rm, v2, rn, acc);
        chk({nm, "_ov0"}, 32'(out_valid), 32'd0);
        n = 0; low = 0;
        while (!out_valid && n < 30) begin
            if (!in_ready) low++;
            @(posedge clk); #1;
            n++;
        end
        chk({nm, "_lat"}, n, 8);
        chk({nm, "_rdylow"}, low, 8);
        chk({nm, "_res"}, alu_res, exp);
        chk({nm, "_st"}, 32'(status_out), 32'b0011);
        chk({nm, "_swe"}, 32'(status_we), 32'd1);
        chk({nm, "_dst"}, 32'(dest_out), 32'h7);
        chk({nm, "_stv"}, st_val, rm);
        chk({nm, "_rdy"}, 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        chk({nm, "_bub"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int n;
        int seen;
        logic [31:0] held;

        vecs[0]  = '{4'b0010, 32'd5, 32'd7, 4'b0000, 32'd12, 4'b0000};
        vecs[1]  = '{4'b0100, 32'd3, 32'd5, 4'b0000, 32'hFFFFFFFE, 4'b1000};
        vecs[2]  = '{4'b0010, 32'h7FFFFFFF, 32'd1, 4'b0000, 32'h80000000, 4'b1001};
        vecs[3]  = '{4'b0010, 32'hFFFFFFFF, 32'd1, 4'b0000, 32'h0, 4'b0110};
        vecs[4]  = '{4'b0100, 32'd5, 32'd5, 4'b0000, 32'h0, 4'b0110};
        vecs[5]  = '{4'b0011, 32'd1, 32'd1, 4'b0010, 32'd3, 4'b0000};
        vecs[6]  = '{4'b0101, 32'd5, 32'd3, 4'b0000, 32'd1, 4'b0010};
        vecs[7]  = '{4'b0110, 32'hF0F0, 32'hFF00, 4'b1111, 32'hF000, 4'b0011};
        vecs[8]  = '{4'b0111, 32'h0F, 32'hF0, 4'b0000, 32'hFF, 4'b0000};
        vecs[9]  = '{4'b1000, 32'hFFFFFFFF, 32'hFFFFFFFF, 4'b0001, 32'h0, 4'b0101};
        vecs[10] = '{4'b0001, 32'd9, 32'h80000000, 4'b0010, 32'h80000000, 4'b1010};
        vecs[11] = '{4'b1001, 32'd9, 32'h0, 4'b0000, 32'hFFFFFFFF, 4'b1000};
        vecs[12] = '{4'b0000, 32'd9, 32'd9, 4'b1010, 32'h0, 4'b1010};
        vecs[13] = '{4'b0100, 32'h80000000, 32'd1, 4'b0000, 32'h7FFFFFFF, 4'b0011};

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ov", 32'(out_valid), 32'd0);
        chk("rst_res", alu_res, 32'd0);
        chk("rst_st", 32'(status_out), 32'd0);
        chk("rst_rdy", 32'(in_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            in_valid = 1'b1; s_in = 1'b1;
            exe_cmd_in = vecs[i].cmd; val_rn = vecs[i].rn;
            val2_in = vecs[i].v2; status_in = vecs[i].st_in;
            @(posedge clk); #1;
            chk($sformatf("alu%0d_ov", i), 32'(out_valid), 32'd1);
            chk($sformatf("alu%0d_res", i), alu_res, vecs[i].res);
            chk($sformatf("alu%0d_st", i), 32'(status_out), 32'(vecs[i].st));
            chk($sformatf("alu%0d_swe", i), 32'(status_we), 32'd1);
        end
        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
        chk("bubble_ov", 32'(out_valid), 32'd0);
        chk("bubble_swe", 32'(status_we), 32'd0);

        @(negedge clk);
        in_valid = 1'b1; exe_cmd_in = 4'b0010; pc_in = 32'h100;
        imm24 = 24'hFFFFFE; branch_taken_in = 1'b1; dest_in = 4'hA;
        val_rm = 32'hCAFE; mem_read_in = 1'b1; mem_write_in = 1'b1;
        @(posedge clk); #1;
        chk("br_addr", branch_addr, 32'hF8);
        chk("br_out", 32'(branch_out), 32'd1);
        chk("br_pc", pc_out, 32'h100);
        chk("br_swe", 32'(status_we), 32'd0);
        chk("br_dst", 32'(dest_out), 32'hA);
        chk("br_stv", st_val, 32'hCAFE);
        chk("br_mrw", {30'd0, mem_read_out, mem_write_out}, 32'd3);
        @(negedge clk);
        imm24 = 24'h000001;
        @(posedge clk); #1;
        chk("br_addr_fwd", branch_addr, 32'h104);
        @(negedge clk);
        idle_inputs();
        @(posedge clk); #1;
        chk("br_bubble", 32'(branch_out), 32'd0);

        run_mul("mul", 32'h1234, 32'h10, 32'd1, 1'b0, 32'h12340);
        run_mul("mla", 32'h1234, 32'h10, 32'd1, 1'b1, 32'h12341);
        run_mul("mulbig", 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd0, 1'b0, 32'h1);

        start_mul(32'h1234, 32'h10, 32'd1, 1'b1);
        repeat (3) @(posedge clk);
        @(negedge clk);
        freeze = 1'b1;
        held = alu_res;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            if (out_valid || alu_res !== held) seen++;
        end
        chk("frz_stable", seen, 0);
        @(negedge clk);
        freeze = 1'b0;
        wait_valid(30, n);
        chk("frz_lat", n, 5);
        chk("frz_res", alu_res, 32'h12341);

        @(negedge clk);
        in_valid = 1'b1; exe_cmd_in = 4'b0010; val_rn = 32'd1;
        val2_in = 32'd1; s_in = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        chk("flush_idle_ov", 32'(out_valid), 32'd0);
        @(negedge clk);
        idle_inputs();

        start_mul(32'h1234, 32'h10, 32'd0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        flush = 1'b1; in_valid = 1'b1; s_in = 1'b1; exe_cmd_in = 4'b0010;
        @(posedge clk); #1;
        chk("flush_ov", 32'(out_valid), 32'd0);
        chk("flush_swe", 32'(status_we), 32'd0);
        chk("flush_rdy", 32'(in_ready), 32'd1);
        @(negedge clk);
        idle_inputs();
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (out_valid || status_we) seen++;
        end
        chk("flush_quiet", seen, 0);

        start_mul(32'h1234, 32'h10, 32'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b1; flush = 1'b1;
        @(posedge clk); #1;
        chk("rstm_ov", 32'(out_valid), 32'd0);
        chk("rstm_res", alu_res, 32'd0);
        chk("rstm_pc", pc_out, 32'd0);
        chk("rstm_baddr", branch_addr, 32'd0);
        chk("rstm_stv", st_val, 32'd0);
        chk("rstm_dst", 32'(dest_out), 32'd0);
        @(negedge clk);
        rst = 1'b0; flush = 1'b0;
        #1;
        chk("rstm_rdy", 32'(in_ready), 32'd1);
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("rstm_quiet", seen, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
